branch_predictor: RTL and testbench

- Direction predictor directly upstream of the branch handler.
- Holds a table of 2-bit saturating counters indexed by low PC bits.
- Each cycle it drives the taken/not-taken prediction for the instruction in ID.
- Trains on the resolved outcome of the branch in EX and keeps branch and misprediction statistics.

---
 rtl/bp_pkg.sv | 32 +++
 rtl/bp_counter_table.sv | 43 ++++
 rtl/branch_predictor.sv | 117 +++++++++++
 tb/tb_branch_predictor.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared definitions for the branch direction predictor.
//   - bp_cnt_e     : 2-bit saturating counter encoding (SNT/WNT/WT/ST)
//   - BP_CNT_RST   : counter value after reset (weakly not-taken)
//   - BP_STAT_W    : width of the branch/mispredict statistics counters
//   - bp_cnt_next  : saturating counter next-state function
package bp_pkg;

  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_cnt_e;

  localparam bp_cnt_e     BP_CNT_RST = BP_WNT;
  localparam int unsigned BP_STAT_W  = 16;

  // Move one step toward taken/not-taken, holding at the strong ends.
  function automatic bp_cnt_e bp_cnt_next(input bp_cnt_e cnt, input logic taken);
    bp_cnt_e nxt;
    nxt = cnt;
    case (cnt)
      BP_SNT: if (taken) nxt = BP_WNT;
      BP_WNT: if (taken) nxt = BP_WT;  else nxt = BP_SNT;
      BP_WT:  if (taken) nxt = BP_ST;  else nxt = BP_WNT;
      BP_ST:  if (!taken) nxt = BP_WT;
      default: nxt = BP_CNT_RST;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// bp_counter_table: ENTRIES x 2-bit saturating counter array.
// Ports:
//   clk_i, rst_i   clock; asynchronous active-high reset (all entries -> BP_CNT_RST)
//   rd_idx_i       combinational read index
//   rd_cnt_o       counter value at rd_idx_i (pre-update value on a same-cycle write)
//   we_i           write enable; counter at wr_idx_i steps on the rising edge
//   wr_idx_i       write index
//   wr_taken_i     direction of the step (1 = toward taken)
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  localparam int unsigned IDXW = $clog2(ENTRIES)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [IDXW-1:0] rd_idx_i,
  output logic [1:0]      rd_cnt_o,
  input  logic            we_i,
  input  logic [IDXW-1:0] wr_idx_i,
  input  logic            wr_taken_i
);

  bp_cnt_e cnt_q [ENTRIES];
  bp_cnt_e wr_cnt_d;

  assign rd_cnt_o = cnt_q[rd_idx_i];

  always_comb begin
    wr_cnt_d = bp_cnt_next(cnt_q[wr_idx_i], wr_taken_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= BP_CNT_RST;
      end
    end else if (we_i) begin
      cnt_q[wr_idx_i] <= wr_cnt_d;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: bimodal (optionally gshare) branch direction predictor.
// Macro BP_GSHARE_EN: when defined, XORs a global history register into the
// lookup index and trains the counter that produced the prediction.
// Ports:
//   clk_i, rst_i        clock; asynchronous active-high reset
//   ID_pc_i             lookup PC (instruction in ID)
//   predict_o           predicted taken for ID_pc_i (combinational)
//   stall_i             ID/EX register held this cycle (gshare index capture only)
//   EX_Branch_i         EX holds a conditional branch; qualifies training/statistics
//   EX_Zero_i           resolved outcome, 1 = taken
//   EX_Predict_i        prediction that travelled with the EX branch
//   EX_pc_i             PC of the EX branch (update address, bimodal mode)
//   branch_cnt_o        resolved branches since reset (wraps)
//   mispredict_cnt_o    mispredicted branches since reset (wraps)
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned INDEX_LSB = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          ID_pc_i,
  output logic                 predict_o,
  input  logic                 stall_i,
  input  logic                 EX_Branch_i,
  input  logic                 EX_Zero_i,
  input  logic                 EX_Predict_i,
  input  logic [31:0]          EX_pc_i,
  output logic [BP_STAT_W-1:0] branch_cnt_o,
  output logic [BP_STAT_W-1:0] mispredict_cnt_o
);

  localparam int unsigned IDXW = $clog2(ENTRIES);

  logic [IDXW-1:0] id_idx;
  logic [IDXW-1:0] ex_idx;
  logic [IDXW-1:0] lookup_idx;
  logic [IDXW-1:0] update_idx;
  logic [1:0]      rd_cnt;

  assign id_idx = ID_pc_i[INDEX_LSB +: IDXW];
  assign ex_idx = EX_pc_i[INDEX_LSB +: IDXW];

`ifdef BP_GSHARE_EN
  logic [IDXW-1:0] ghr_q, ghr_d;
  logic [IDXW-1:0] idx_ex_q, idx_ex_d;

  // The EX PC cannot reproduce the hashed index once the GHR has moved on,
  // so the lookup index is carried alongside the instruction instead.
  always_comb begin
    ghr_d    = ghr_q;
    idx_ex_d = idx_ex_q;
    if (EX_Branch_i) ghr_d = {ghr_q[IDXW-2:0], EX_Zero_i};
    if (!stall_i)    idx_ex_d = lookup_idx;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ghr_q    <= '0;
      idx_ex_q <= '0;
    end else begin
      ghr_q    <= ghr_d;
      idx_ex_q <= idx_ex_d;
    end
  end

  assign lookup_idx = id_idx ^ ghr_q;
  assign update_idx = idx_ex_q;
`else
  assign lookup_idx = id_idx;
  assign update_idx = ex_idx;
`endif

  bp_counter_table #(
    .ENTRIES (ENTRIES)
  ) u_table (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_idx_i   (lookup_idx),
    .rd_cnt_o   (rd_cnt),
    .we_i       (EX_Branch_i),
    .wr_idx_i   (update_idx),
    .wr_taken_i (EX_Zero_i)
  );

  assign predict_o = rd_cnt[1];

  logic [BP_STAT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [BP_STAT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (EX_Branch_i) begin
      branch_cnt_d = branch_cnt_q + 1'b1;
      if (EX_Predict_i != EX_Zero_i) mispredict_cnt_d = mispredict_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

  logic unused_ok;
  assign unused_ok = ^{ID_pc_i, EX_pc_i, stall_i, ex_idx, rd_cnt[0]};

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench for branch_predictor.
// Honors BP_GSHARE_EN the same way as the design.
module tb_branch_predictor;

  localparam int unsigned ENTRIES   = 16;
  localparam int unsigned INDEX_LSB = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] ID_pc_i;
  logic        predict_o;
  logic        stall_i;
  logic        EX_Branch_i;
  logic        EX_Zero_i;
  logic        EX_Predict_i;
  logic [31:0] EX_pc_i;
  logic [15:0] branch_cnt_o;
  logic [15:0] mispredict_cnt_o;

  always #5 clk = ~clk;

  branch_predictor #(
    .ENTRIES   (ENTRIES),
    .INDEX_LSB (INDEX_LSB)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .ID_pc_i          (ID_pc_i),
    .predict_o        (predict_o),
    .stall_i          (stall_i),
    .EX_Branch_i      (EX_Branch_i),
    .EX_Zero_i        (EX_Zero_i),
    .EX_Predict_i     (EX_Predict_i),
    .EX_pc_i          (EX_pc_i),
    .branch_cnt_o     (branch_cnt_o),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic  exp;
    string tag;
  } sb_t;

  sb_t  exp_q[$];
  logic obs_q[$];

  // Reference model: counters as integers 0..3, stats as plain ints.
  int          mdl [ENTRIES];
  int unsigned ghr_m;
  int unsigned idxex_m;
  int          bcnt_m;
  int          mcnt_m;

  function automatic int unsigned lk_idx(input logic [31:0] pc);
    int unsigned i;
    i = (pc >> INDEX_LSB) % ENTRIES;
`ifdef BP_GSHARE_EN
    i = i ^ ghr_m;
`endif
    return i;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) mdl[i] = 1;
    ghr_m = 0; idxex_m = 0; bcnt_m = 0; mcnt_m = 0;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    EX_Branch_i = 1'b0; EX_Zero_i = 1'b0; EX_Predict_i = 1'b0;
    stall_i = 1'b0; ID_pc_i = '0; EX_pc_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    model_reset();
  endtask

  // One cycle of stimulus: expected prediction pushed now, observation
  // captured at the negedge, model advanced for the coming edge.
  task automatic drive(input logic [31:0] id_pc, input logic br, input logic zero,
                       input logic pred, input logic [31:0] ex_pc, input logic stall,
                       input string tag);
    int unsigned li, ui;
    sb_t e;
    ID_pc_i = id_pc; EX_Branch_i = br; EX_Zero_i = zero;
    EX_Predict_i = pred; EX_pc_i = ex_pc; stall_i = stall;
    li = lk_idx(id_pc);
    e.exp = (mdl[li] >= 2);
    e.tag = tag;
    exp_q.push_back(e);
    @(negedge clk);
    obs_q.push_back(predict_o);
`ifdef BP_GSHARE_EN
    ui = idxex_m;
`else
    ui = (ex_pc >> INDEX_LSB) % ENTRIES;
`endif
    if (br) begin
      if (zero) mdl[ui] = (mdl[ui] >= 3) ? 3 : mdl[ui] + 1;
      else      mdl[ui] = (mdl[ui] <= 0) ? 0 : mdl[ui] - 1;
      bcnt_m = (bcnt_m + 1) % 65536;
      if (pred !== zero) mcnt_m = (mcnt_m + 1) % 65536;
    end
`ifdef BP_GSHARE_EN
    if (!stall) idxex_m = li;
    if (br) ghr_m = ((ghr_m << 1) | int'(zero)) % ENTRIES;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sb_t e; logic o;
    drive(32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "reset_predict");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.exp) begin failures++; $display("FAIL %s: predict_o=%b expected %b", e.tag, o, e.exp); end
    end
    checks++;
    if (predict_o !== 1'b0) begin failures++; $display("FAIL reset_predict_const: predict_o=%b expected 0", predict_o); end
    checks++;
    if (branch_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_branch_cnt: got %0d expected 0", branch_cnt_o); end
    checks++;
    if (mispredict_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_mispredict_cnt: got %0d expected 0", mispredict_cnt_o); end
    for (int i = 0; i < ENTRIES; i++) begin
      checks++;
      if (dut.u_table.cnt_q[i] !== 2'b01) begin
        failures++; $display("FAIL reset_entry[%0d]: got %b expected 01", i, dut.u_table.cnt_q[i]);
      end
    end
  endtask

  task automatic test_training();
    sb_t e; logic o;
    for (int i = 0; i < 3; i++) drive(32'h40, 1'b1, 1'b1, 1'b0, 32'h40, 1'b0, "train_taken");
    for (int i = 0; i < 2; i++) drive(32'h40, 1'b1, 1'b0, 1'b1, 32'h40, 1'b0, "train_not_taken");
    drive(32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "train_final");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.exp) begin failures++; $display("FAIL %s: predict_o=%b expected %b", e.tag, o, e.exp); end
    end
    checks++;
    if (branch_cnt_o !== 16'(bcnt_m)) begin failures++; $display("FAIL train_branch_cnt: got %0d expected %0d", branch_cnt_o, bcnt_m); end
  endtask

  task automatic test_aliasing();
    sb_t e; logic o;
    for (int i = 0; i < 2; i++) drive(32'h40, 1'b1, 1'b1, 1'b0, 32'h40, 1'b0, "alias_train");
    drive(32'h80, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "alias_0x80");
    drive(32'h44, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "alias_0x44");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.exp) begin failures++; $display("FAIL %s: predict_o=%b expected %b", e.tag, o, e.exp); end
    end
  endtask

  task automatic test_collision();
    sb_t e; logic o;
    drive(32'h10, 1'b1, 1'b1, 1'b0, 32'h10, 1'b0, "collide_same_cycle");
    drive(32'h10, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, "collide_next_cycle");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.exp) begin failures++; $display("FAIL %s: predict_o=%b expected %b", e.tag, o, e.exp); end
    end
  endtask

  task automatic test_no_update();
    sb_t e; logic o;
    for (int i = 0; i < 4; i++) drive(32'h24, 1'b0, 1'b1, 1'b0, 32'h24, 1'b0, "noupd_hold");
    drive(32'h24, 1'b0, 1'b0, 1'b1, 32'h24, 1'b0, "noupd_after");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.exp) begin failures++; $display("FAIL %s: predict_o=%b expected %b", e.tag, o, e.exp); end
    end
    checks++;
    if (branch_cnt_o !== 16'(bcnt_m)) begin failures++; $display("FAIL noupd_branch_cnt: got %0d expected %0d", branch_cnt_o, bcnt_m); end
    checks++;
    if (mispredict_cnt_o !== 16'(mcnt_m)) begin failures++; $display("FAIL noupd_mispredict_cnt: got %0d expected %0d", mispredict_cnt_o, mcnt_m); end
  endtask

  task automatic test_stats();
    logic z;
    apply_reset();
    for (int i = 0; i < 70000; i++) begin
      z = ((i % 2) == 1);
      ID_pc_i = 32'h0; stall_i = 1'b0; EX_Branch_i = 1'b1; EX_Zero_i = z;
      EX_Predict_i = z ^ ((i % 4) == 0);
      EX_pc_i = 32'(i * 4);
      @(posedge clk);
      #1;
    end
    EX_Branch_i = 1'b0;
    ID_pc_i = 32'h40;
    @(negedge clk);
    checks++;
    if (branch_cnt_o !== 16'd4464) begin failures++; $display("FAIL stats_branch_cnt: got %0d expected 4464", branch_cnt_o); end
    checks++;
    if (mispredict_cnt_o !== 16'd17500) begin failures++; $display("FAIL stats_mispredict_cnt: got %0d expected 17500", mispredict_cnt_o); end
    // Asynchronous reset mid-cycle; observe before any further edge.
    @(posedge clk);
    #3 rst_i = 1'b1;
    #1;
    checks++;
    if (branch_cnt_o !== 16'd0) begin failures++; $display("FAIL async_rst_branch_cnt: got %0d expected 0", branch_cnt_o); end
    checks++;
    if (mispredict_cnt_o !== 16'd0) begin failures++; $display("FAIL async_rst_mispredict_cnt: got %0d expected 0", mispredict_cnt_o); end
    checks++;
    if (predict_o !== 1'b0) begin failures++; $display("FAIL async_rst_predict: got %b expected 0", predict_o); end
    for (int i = 0; i < ENTRIES; i++) begin
      checks++;
      if (dut.u_table.cnt_q[i] !== 2'b01) begin
        failures++; $display("FAIL async_rst_entry[%0d]: got %b expected 01", i, dut.u_table.cnt_q[i]);
      end
    end
    @(posedge clk);
    #1 rst_i = 1'b0;
    model_reset();
  endtask

  // Alternating T/NT branch at 0x20: lookup cycle, optional stall cycle
  // (with a different PC in ID), then the EX cycle carrying the outcome.
  task automatic test_alternating(input logic use_stall, input string tag);
    sb_t e; logic o; logic p; logic outcome;
    int late_miss;
    apply_reset();
    late_miss = 0;
    for (int k = 0; k < 20; k++) begin
      outcome = ((k % 2) == 0);
      p = (mdl[lk_idx(32'h20)] >= 2);
      if (k >= 10 && p !== outcome) late_miss++;
      drive(32'h20, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, tag);
      if (use_stall) drive(32'h1FC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, tag);
      drive(32'h100, 1'b1, outcome, p, 32'h20, 1'b0, tag);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.exp) begin failures++; $display("FAIL %s: predict_o=%b expected %b", e.tag, o, e.exp); end
    end
    checks++;
`ifdef BP_GSHARE_EN
    if (late_miss !== 0) begin failures++; $display("FAIL %s_settled: late mispredicts=%0d expected 0", tag, late_miss); end
`else
    if (late_miss !== 10) begin failures++; $display("FAIL %s_bimodal: late mispredicts=%0d expected 10", tag, late_miss); end
`endif
    checks++;
    if (mispredict_cnt_o !== 16'(mcnt_m)) begin failures++; $display("FAIL %s_mispredict_cnt: got %0d expected %0d", tag, mispredict_cnt_o, mcnt_m); end
    checks++;
    if (branch_cnt_o !== 16'd20) begin failures++; $display("FAIL %s_branch_cnt: got %0d expected 20", tag, branch_cnt_o); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();
    test_reset();
    test_training();
    test_aliasing();
    test_collision();
    test_no_update();
    test_stats();
    test_alternating(1'b0, "alt_plain");
    test_alternating(1'b1, "alt_stall");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
